// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: widths, FSM states and
// the filler values reported on quotient overflow or divide-by-zero.
package mdu_pkg;

   localparam int unsigned N     = 16;  // operand / quotient width
   localparam int unsigned CNT_W = 4;   // iteration counter width (N iterations)

   typedef logic [1:0] state_t;

   localparam state_t IDLE = 2'd0;
   localparam state_t CALC = 2'd1;
   localparam state_t DONE = 2'd2;

   localparam logic [N-1:0] OVF_QUO = 16'hFFFF;
   localparam logic [N-1:0] OVF_REM = 16'h0000;

endpackage

// File: rtl/div_passo.sv
// One restoring-division iteration: shift {R,Q} left, trial-subtract the
// divisor from R and either keep the difference (quotient bit 1) or restore
// R (quotient bit 0).
module div_passo
   import mdu_pkg::*;
(
   input  logic [N:0]   r_in,
   input  logic [N-1:0] q_in,
   input  logic [N-1:0] divisor,
   output logic [N:0]   r_out,
   output logic [N-1:0] q_out
);

   logic [N+1:0] r_sh;
   logic [N+1:0] diff;

   // Trial subtraction; the extra top bit of diff is the borrow, so a clear
   // top bit means the shifted remainder was at least the divisor.
   always_comb begin
      r_sh = {r_in, q_in[N-1]};
      diff = r_sh - {2'b00, divisor};
      if (!diff[N+1]) begin
         r_out = diff[N:0];
         q_out = {q_in[N-2:0], 1'b1};
      end else begin
         r_out = r_sh[N:0];
         q_out = {q_in[N-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/divisor_sequencial.sv
// Sequential restoring divider: 32-bit dividend / 16-bit divisor, one
// quotient bit per clock, with start/idle/done handshake.
module divisor_sequencial
   import mdu_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          St,
   input  logic [2*N-1:0] Dividendo,
   input  logic [N-1:0]  Divisor,
   output logic          Idle,
   output logic          Done,
   output logic [N-1:0]  Quociente,
   output logic [N-1:0]  Resto,
   output logic          Ovf
);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [N:0]       r_reg;
   logic [N-1:0]     q_reg;
   logic [N-1:0]     div_reg;
   logic [N:0]       r_next;
   logic [N-1:0]     q_next;

   div_passo u_passo (
      .r_in    (r_reg),
      .q_in    (q_reg),
      .divisor (div_reg),
      .r_out   (r_next),
      .q_out   (q_next)
   );

   // Status outputs decoded directly from the state register.
   assign Idle = (state == IDLE);
   assign Done = (state == DONE);

   // FSM, iteration counter, working registers and held results.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         r_reg     <= '0;
         q_reg     <= '0;
         div_reg   <= '0;
         Quociente <= '0;
         Resto     <= '0;
         Ovf       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (St) begin
                  div_reg <= Divisor;
                  cnt     <= '0;
                  // A high half >= divisor cannot give a 16-bit quotient;
                  // this also catches divide-by-zero.
                  if (Dividendo[2*N-1:N] >= Divisor) begin
                     state     <= DONE;
                     Quociente <= OVF_QUO;
                     Resto     <= OVF_REM;
                     Ovf       <= 1'b1;
                  end else begin
                     r_reg <= {1'b0, Dividendo[2*N-1:N]};
                     q_reg <= Dividendo[N-1:0];
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               r_reg <= r_next;
               q_reg <= q_next;
               cnt   <= cnt + 1'b1;
               if (cnt == '1) begin
                  state     <= DONE;
                  Quociente <= q_next;
                  Resto     <= r_next[N-1:0];
                  Ovf       <= 1'b0;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_divisor_sequencial.sv
// Self-checking bench for divisor_sequencial against an arithmetic model.
module tb_divisor_sequencial;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        St = 1'b0;
   logic [31:0] Dividendo = '0;
   logic [15:0] Divisor = '0;
   logic        Idle;
   logic        Done;
   logic [15:0] Quociente;
   logic [15:0] Resto;
   logic        Ovf;

   int checks = 0;
   int failures = 0;

   divisor_sequencial dut (
      .clk       (clk),
      .rst       (rst),
      .St        (St),
      .Dividendo (Dividendo),
      .Divisor   (Divisor),
      .Idle      (Idle),
      .Done      (Done),
      .Quociente (Quociente),
      .Resto     (Resto),
      .Ovf       (Ovf)
   );

   always #5 clk = ~clk;

   // Reference: {ovf, quotient, remainder} from plain integer division.
   function automatic logic [32:0] model(input logic [31:0] dd, input logic [15:0] dv);
      logic [31:0] q;
      logic [31:0] r;
      if (dd[31:16] >= dv) return {1'b1, 16'hFFFF, 16'h0000};
      q = dd / {16'h0, dv};
      r = dd % {16'h0, dv};
      return {1'b0, q[15:0], r[15:0]};
   endfunction

   // Random operands, biased so most are in the non-overflow range.
   task automatic rand_ops(output logic [31:0] dd, output logic [15:0] dv);
      logic [15:0] hi;
      dv = 16'($urandom_range(1, 65535));
      if ($urandom_range(0, 15) == 0) dv = 16'h0;
      if ($urandom_range(0, 3) != 0 && dv != 0) hi = 16'($urandom_range(0, int'(dv) - 1));
      else hi = 16'($urandom);
      dd = {hi, 16'($urandom)};
   endtask

   // Start one division and wait (bounded) for Done. lat is the index of the
   // first falling-edge sample after the start edge that sees Done (1 = the
   // cycle right after the start edge), or -1 on timeout.
   task automatic run_div(input logic [31:0] dd, input logic [15:0] dv, input bit noise,
                          output int lat, output int idle_low,
                          output logic [15:0] q, output logic [15:0] r, output logic o,
                          output logic [15:0] q_mid,
                          output logic done_after, output logic idle_after);
      lat = -1; idle_low = 0; q = '0; r = '0; o = 1'b0; q_mid = '0;
      @(negedge clk);
      Dividendo = dd; Divisor = dv; St = 1'b1;
      @(posedge clk);
      #1 St = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (!Idle) idle_low++;
         if (k == 8) q_mid = Quociente;
         if (Done) begin
            lat = k; q = Quociente; r = Resto; o = Ovf;
            break;
         end
         if (noise) begin
            St = 1'($urandom_range(0, 1));
            Dividendo = $urandom;
            Divisor = 16'($urandom);
         end
      end
      St = 1'b0;
      @(negedge clk);
      done_after = Done;
      idle_after = Idle;
   endtask

   task automatic test_reset;
      #1;
      checks++;
      if (Idle !== 1'b1 || Done !== 1'b0 || Quociente !== 16'h0 || Resto !== 16'h0 || Ovf !== 1'b0) begin
         failures++;
         $display("FAIL reset: got Idle=%b Done=%b Q=%h R=%h Ovf=%b, want 1 0 0000 0000 0",
                  Idle, Done, Quociente, Resto, Ovf);
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_basic;
      int lat, il; logic [15:0] q, r, qm; logic o, da, ia;
      run_div(32'd30000000, 16'd6000, 1'b0, lat, il, q, r, o, qm, da, ia);
      checks++;
      if (lat !== 17) begin failures++; $display("FAIL basic_latency: got %0d want 17", lat); end
      checks++;
      if (q !== 16'd5000 || r !== 16'd0 || o !== 1'b0) begin
         failures++; $display("FAIL basic_result: got Q=%0d R=%0d Ovf=%b want 5000 0 0", q, r, o);
      end
      // Idle is low from the start edge until the DONE->IDLE edge: 17 periods.
      checks++;
      if (il !== 17) begin failures++; $display("FAIL basic_idle_low: got %0d want 17", il); end
      checks++;
      if (da !== 1'b0 || ia !== 1'b1) begin
         failures++; $display("FAIL basic_done_pulse: got Done=%b Idle=%b after pulse want 0 1", da, ia);
      end
   endtask

   task automatic test_sequence;
      int lat, il; logic [15:0] q, r, qm; logic o, da, ia;
      run_div(32'd131, 16'd10, 1'b0, lat, il, q, r, o, qm, da, ia);
      checks++;
      if (q !== 16'd13 || r !== 16'd1 || o !== 1'b0 || lat !== 17) begin
         failures++; $display("FAIL seq_131_10: got Q=%0d R=%0d Ovf=%b lat=%0d want 13 1 0 17", q, r, o, lat);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (Quociente !== 16'd13 || Resto !== 16'd1) begin
         failures++; $display("FAIL seq_hold_idle: got Q=%0d R=%0d want 13 1", Quociente, Resto);
      end
      run_div(32'd45, 16'd3, 1'b0, lat, il, q, r, o, qm, da, ia);
      checks++;
      if (qm !== 16'd13) begin failures++; $display("FAIL seq_hold_calc: got Q=%0d want 13", qm); end
      checks++;
      if (q !== 16'd15 || r !== 16'd0 || o !== 1'b0) begin
         failures++; $display("FAIL seq_45_3: got Q=%0d R=%0d Ovf=%b want 15 0 0", q, r, o);
      end
   endtask

   task automatic test_boundary;
      int lat, il; logic [15:0] q, r, qm; logic o, da, ia;
      run_div(32'hFFFE0001, 16'hFFFF, 1'b0, lat, il, q, r, o, qm, da, ia);
      checks++;
      if (q !== 16'hFFFF || r !== 16'h0 || o !== 1'b0 || lat !== 17) begin
         failures++; $display("FAIL boundary: got Q=%h R=%h Ovf=%b lat=%0d want ffff 0000 0 17", q, r, o, lat);
      end
   endtask

   task automatic test_overflow;
      int lat, il; logic [15:0] q, r, qm; logic o, da, ia;
      logic [31:0] dd;
      run_div(32'h00010000, 16'd1, 1'b0, lat, il, q, r, o, qm, da, ia);
      checks++;
      if (q !== 16'hFFFF || r !== 16'h0 || o !== 1'b1 || lat !== 1) begin
         failures++; $display("FAIL ovf_result: got Q=%h R=%h Ovf=%b lat=%0d want ffff 0000 1 1", q, r, o, lat);
      end
      checks++;
      if (da !== 1'b0 || ia !== 1'b1) begin
         failures++; $display("FAIL ovf_done_pulse: got Done=%b Idle=%b want 0 1", da, ia);
      end
      dd = $urandom;
      run_div(dd, 16'd0, 1'b0, lat, il, q, r, o, qm, da, ia);
      checks++;
      if (q !== 16'hFFFF || r !== 16'h0 || o !== 1'b1 || lat !== 1) begin
         failures++; $display("FAIL div_zero: dd=%h got Q=%h R=%h Ovf=%b lat=%0d want ffff 0000 1 1", dd, q, r, o, lat);
      end
      // Ovf must clear again on the next good division.
      run_div(32'd100, 16'd7, 1'b0, lat, il, q, r, o, qm, da, ia);
      checks++;
      if (q !== 16'd14 || r !== 16'd2 || o !== 1'b0) begin
         failures++; $display("FAIL ovf_clear: got Q=%0d R=%0d Ovf=%b want 14 2 0", q, r, o);
      end
   endtask

   task automatic test_abort;
      int lat, il; logic [15:0] q, r, qm; logic o, da, ia;
      int seen_done;
      @(negedge clk);
      Dividendo = 32'd1000; Divisor = 16'd7; St = 1'b1;
      @(posedge clk);
      #1 St = 1'b0;
      repeat (8) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      checks++;
      if (Idle !== 1'b1 || Done !== 1'b0 || Quociente !== 16'h0 || Resto !== 16'h0 || Ovf !== 1'b0) begin
         failures++;
         $display("FAIL abort_reset: got Idle=%b Done=%b Q=%h R=%h Ovf=%b want 1 0 0000 0000 0",
                  Idle, Done, Quociente, Resto, Ovf);
      end
      seen_done = 0;
      repeat (12) begin
         @(negedge clk);
         if (Done) seen_done++;
      end
      rst = 1'b1;
      repeat (12) begin
         @(negedge clk);
         if (Done) seen_done++;
      end
      checks++;
      if (seen_done !== 0) begin failures++; $display("FAIL abort_no_done: got %0d Done cycles want 0", seen_done); end
      run_div(32'd1000, 16'd7, 1'b0, lat, il, q, r, o, qm, da, ia);
      checks++;
      if (q !== 16'd142 || r !== 16'd6 || o !== 1'b0 || lat !== 17) begin
         failures++; $display("FAIL abort_restart: got Q=%0d R=%0d Ovf=%b lat=%0d want 142 6 0 17", q, r, o, lat);
      end
   endtask

   task automatic test_ignore_st;
      int lat, il; logic [15:0] q, r, qm; logic o, da, ia;
      logic [31:0] dd; logic [15:0] dv; logic [32:0] exp;
      for (int i = 0; i < 4; i++) begin
         dv = 16'($urandom_range(1, 65535));
         dd = {16'($urandom_range(0, int'(dv) - 1)), 16'($urandom)};
         exp = model(dd, dv);
         run_div(dd, dv, 1'b1, lat, il, q, r, o, qm, da, ia);
         checks++;
         if ({o, q, r} !== exp || lat !== 17 || ia !== 1'b1) begin
            failures++;
            $display("FAIL ignore_st: %0d/%0d got Q=%0d R=%0d Ovf=%b lat=%0d idle=%b want Q=%0d R=%0d Ovf=%b lat=17 idle=1",
                     dd, dv, q, r, o, lat, ia, exp[31:16], exp[15:0], exp[32]);
         end
      end
   endtask

   // St held high: each accept is seen as Idle=1 at the falling edge before
   // it; operands are scrambled while busy to check they were latched.
   task automatic test_back_to_back;
      logic [32:0] exp_q[$];
      logic [31:0] dd_q[$];
      logic [15:0] dv_q[$];
      logic [32:0] exp;
      logic [31:0] edd;
      logic [15:0] edv;
      logic [31:0] dd;
      logic [15:0] dv;
      int last_acc;
      logic last_ovf;
      int accepts;
      last_acc = -1; last_ovf = 1'b0; accepts = 0;
      @(negedge clk);
      rand_ops(dd, dv);
      Dividendo = dd; Divisor = dv; St = 1'b1;
      for (int cyc = 0; cyc < 900; cyc++) begin
         if (cyc != 0) @(negedge clk);
         if (Done) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++; $display("FAIL b2b_extra_done: cycle %0d got Done=1 want 0", cyc);
            end else begin
               exp = exp_q.pop_front(); edd = dd_q.pop_front(); edv = dv_q.pop_front();
               if ({Ovf, Quociente, Resto} !== exp) begin
                  failures++;
                  $display("FAIL b2b_result: %h/%h got Q=%h R=%h Ovf=%b want Q=%h R=%h Ovf=%b",
                           edd, edv, Quociente, Resto, Ovf, exp[31:16], exp[15:0], exp[32]);
               end else if (!Ovf && ({16'h0, Quociente} * {16'h0, edv} + {16'h0, Resto} != edd
                                     || Resto >= edv)) begin
                  failures++;
                  $display("FAIL b2b_invariant: %h/%h got Q=%h R=%h", edd, edv, Quociente, Resto);
               end
            end
         end
         if (cyc >= 800) St = 1'b0;
         if (Idle && St) begin
            if (last_acc >= 0) begin
               checks++;
               if (cyc - last_acc != (last_ovf ? 2 : 18)) begin
                  failures++;
                  $display("FAIL b2b_spacing: got %0d cycles want %0d", cyc - last_acc, last_ovf ? 2 : 18);
               end
            end
            exp = model(Dividendo, Divisor);
            exp_q.push_back(exp); dd_q.push_back(Dividendo); dv_q.push_back(Divisor);
            last_acc = cyc; last_ovf = exp[32]; accepts++;
         end else if (!Idle) begin
            rand_ops(dd, dv);
            Dividendo = dd; Divisor = dv;
         end
      end
      St = 1'b0;
      checks++;
      if (exp_q.size() != 0 || accepts < 40) begin
         failures++; $display("FAIL b2b_drain: got pending=%0d accepts=%0d want 0 and >=40", exp_q.size(), accepts);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_sequence();
      test_boundary();
      test_overflow();
      test_abort();
      test_ignore_st();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
